// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data RAM between the core (C) and an external port (E).
// Optional starvation guard for locked transfers: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_c,
  input  logic              req_e,
  input  logic              we_c,
  input  logic              we_e,
  input  logic              lock_c,
  input  logic              lock_e,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [ADDR_W-1:0] addr_e,
  input  logic [DATA_W-1:0] wdata_c,
  input  logic [DATA_W-1:0] wdata_e,
  output logic              gnt_c,
  output logic              gnt_e,
  output logic              rvalid_c,
  output logic              rvalid_e,
  output logic [DATA_W-1:0] rdata_c,
  output logic [DATA_W-1:0] rdata_e,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_E = 2'd2
  } state_t;

  if ((MAX_WAIT < 2) || (MAX_WAIT > 255)) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be within 2..255");
  end

  state_t state_r;
  state_t state_nxt_s;
  logic   last_r;
  logic   last_nxt_s;
  logic   gnt_c_s;
  logic   gnt_e_s;
  logic   rvalid_c_r;
  logic   rvalid_e_r;
  logic   starve_c_s;
  logic   starve_e_s;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

  logic [7:0] wait_c_r;
  logic [7:0] wait_e_r;

  // Saturating per-requester wait counters; cleared on grant or when the request goes away
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wait_c_r <= 8'd0;
      wait_e_r <= 8'd0;
    end else begin
      if (!req_c || gnt_c_s) begin
        wait_c_r <= 8'd0;
      end else if (wait_c_r != 8'hFF) begin
        wait_c_r <= wait_c_r + 8'd1;
      end else begin
        wait_c_r <= wait_c_r;
      end
      if (!req_e || gnt_e_s) begin
        wait_e_r <= 8'd0;
      end else if (wait_e_r != 8'hFF) begin
        wait_e_r <= wait_e_r + 8'd1;
      end else begin
        wait_e_r <= wait_e_r;
      end
    end
  end

  assign starve_c_s = req_c && (wait_c_r >= MAX_WAIT_L);
  assign starve_e_s = req_e && (wait_e_r >= MAX_WAIT_L);
`else
  assign starve_c_s = 1'b0;
  assign starve_e_s = 1'b0;
`endif

  // Grant selection and next-state/last-winner computation
  always_comb begin
    gnt_c_s     = 1'b0;
    gnt_e_s     = 1'b0;
    state_nxt_s = IDLE;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (req_c && req_e) begin
          // last_r = 1 means E won most recently, so C takes the tie
          if (last_r) begin
            gnt_c_s = 1'b1;
          end else begin
            gnt_e_s = 1'b1;
          end
        end else if (req_c) begin
          gnt_c_s = 1'b1;
        end else if (req_e) begin
          gnt_e_s = 1'b1;
        end else begin
          gnt_c_s = 1'b0;
        end
      end
      OWN_C: begin
        if (starve_e_s) begin
          gnt_e_s = 1'b1;
        end else if (req_c) begin
          gnt_c_s = 1'b1;
        end else begin
          gnt_c_s = 1'b0;
        end
      end
      OWN_E: begin
        if (starve_c_s) begin
          gnt_c_s = 1'b1;
        end else if (req_e) begin
          gnt_e_s = 1'b1;
        end else begin
          gnt_e_s = 1'b0;
        end
      end
      default: begin
        gnt_c_s = 1'b0;
        gnt_e_s = 1'b0;
      end
    endcase

    if (gnt_c_s) begin
      last_nxt_s  = 1'b0;
      state_nxt_s = lock_c ? OWN_C : IDLE;
    end else if (gnt_e_s) begin
      last_nxt_s  = 1'b1;
      state_nxt_s = lock_e ? OWN_E : IDLE;
    end else if (state_r == OWN_C) begin
      state_nxt_s = lock_c ? OWN_C : IDLE;
    end else if (state_r == OWN_E) begin
      state_nxt_s = lock_e ? OWN_E : IDLE;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // State, last winner and read-valid registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      rvalid_c_r <= 1'b0;
      rvalid_e_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_r     <= last_nxt_s;
      rvalid_c_r <= gnt_c_s & ~we_c;
      rvalid_e_r <= gnt_e_s & ~we_e;
    end
  end

  // Grants are combinational but must read as 0 for the whole time Reset is low
  assign gnt_c    = gnt_c_s & Reset;
  assign gnt_e    = gnt_e_s & Reset;
  assign rvalid_c = rvalid_c_r;
  assign rvalid_e = rvalid_e_r;
  assign rdata_c  = mem_rdata;
  assign rdata_e  = mem_rdata;

  assign mem_en    = gnt_c | gnt_e;
  assign mem_we    = gnt_c ? we_c    : (gnt_e ? we_e    : 1'b0);
  assign mem_addr  = gnt_c ? addr_c  : (gnt_e ? addr_e  : {ADDR_W{1'b0}});
  assign mem_wdata = gnt_c ? wdata_c : (gnt_e ? wdata_e : {DATA_W{1'b0}});

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus reset-mid-lock and starvation sequences.
module tb_dmem_arbiter;

  logic        CLK;
  logic        Reset;
  logic        req_c, req_e, we_c, we_e, lock_c, lock_e;
  logic [31:0] addr_c, addr_e, wdata_c, wdata_e;
  logic        gnt_c, gnt_e, rvalid_c, rvalid_e;
  logic [31:0] rdata_c, rdata_e;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram [0:63];
  int          total;
  int          passed;
  logic        starve_en;

  typedef struct {
    logic        rc, re, wc, we, lc, le;
    logic [31:0] ac, ae, dc, de;
    logic        gc, ge, mwe;
    logic [31:0] ma, md;
    logic        rvc, rve;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [23];

  dmem_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .req_c(req_c), .req_e(req_e), .we_c(we_c), .we_e(we_e),
    .lock_c(lock_c), .lock_e(lock_e),
    .addr_c(addr_c), .addr_e(addr_e), .wdata_c(wdata_c), .wdata_e(wdata_e),
    .gnt_c(gnt_c), .gnt_e(gnt_e), .rvalid_c(rvalid_c), .rvalid_e(rvalid_e),
    .rdata_c(rdata_c), .rdata_e(rdata_e),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous-read RAM; preloaded while reset is held
  always @(posedge CLK) begin
    if (!Reset) begin
      ram[4]    <= 32'hDEADBEEF;
      ram[5]    <= 32'h14141414;
      ram[6]    <= 32'h18181818;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  function automatic vec_t mk(input logic rc, re, wc, we, lc, le,
                              input logic [31:0] ac, ae, dc, de,
                              input logic gc, ge, mwe,
                              input logic [31:0] ma, md,
                              input logic rvc, rve,
                              input logic [31:0] rd);
    vec_t v;
    v.rc = rc; v.re = re; v.wc = wc; v.we = we; v.lc = lc; v.le = le;
    v.ac = ac; v.ae = ae; v.dc = dc; v.de = de;
    v.gc = gc; v.ge = ge; v.mwe = mwe; v.ma = ma; v.md = md;
    v.rvc = rvc; v.rve = rve; v.rd = rd;
    return v;
  endfunction

  task automatic drv(input logic rc, re, wc, we, lc, le, input logic [31:0] ac, ae, dc, de);
    req_c = rc; req_e = re; we_c = wc; we_e = we; lock_c = lc; lock_e = le;
    addr_c = ac; addr_e = ae; wdata_c = dc; wdata_e = de;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial begin
    total = 0;
    passed = 0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    starve_en = 1'b1;
`else
    starve_en = 1'b0;
`endif
    //                rc re wc we lc le  ac     ae     dc  de      gc ge mwe ma     md      rvc rve rd
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 32'h0,  0, 0, 0, 32'h0,  32'h0,  0, 0, 32'h0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 32'h10, 32'h0,  0, 32'h0,  1, 0, 0, 32'h10, 32'h0,  0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 32'h0,  0, 0, 0, 32'h0,  32'h0,  1, 0, 32'hDEADBEEF);
    vecs[3]  = mk(1, 1, 0, 0, 0, 0, 32'h14, 32'h18, 0, 32'h0,  0, 1, 0, 32'h18, 32'h0,  0, 0, 32'h0);
    vecs[4]  = mk(1, 1, 0, 0, 0, 0, 32'h14, 32'h18, 0, 32'h0,  1, 0, 0, 32'h14, 32'h0,  0, 1, 32'h18181818);
    vecs[5]  = mk(1, 1, 0, 0, 0, 0, 32'h14, 32'h18, 0, 32'h0,  0, 1, 0, 32'h18, 32'h0,  1, 0, 32'h14141414);
    vecs[6]  = mk(1, 1, 0, 0, 0, 0, 32'h14, 32'h18, 0, 32'h0,  1, 0, 0, 32'h14, 32'h0,  0, 1, 32'h18181818);
    vecs[7]  = mk(1, 1, 0, 1, 0, 1, 32'h14, 32'h20, 0, 32'hAA, 0, 1, 1, 32'h20, 32'hAA, 1, 0, 32'h14141414);
    vecs[8]  = mk(1, 1, 0, 1, 0, 1, 32'h14, 32'h24, 0, 32'hAB, 0, 1, 1, 32'h24, 32'hAB, 0, 0, 32'h0);
    vecs[9]  = mk(1, 1, 0, 1, 0, 1, 32'h14, 32'h28, 0, 32'hAC, 0, 1, 1, 32'h28, 32'hAC, 0, 0, 32'h0);
    vecs[10] = mk(1, 1, 0, 1, 0, 0, 32'h14, 32'h2C, 0, 32'hAD, 0, 1, 1, 32'h2C, 32'hAD, 0, 0, 32'h0);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 32'h14, 32'h0,  0, 32'h0,  1, 0, 0, 32'h14, 32'h0,  0, 0, 32'h0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 32'h20, 32'h0,  0, 32'h0,  1, 0, 0, 32'h20, 32'h0,  1, 0, 32'h14141414);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 32'h0,  0, 0, 0, 32'h0,  32'h0,  1, 0, 32'hAA);
    vecs[14] = mk(0, 1, 0, 0, 0, 1, 32'h0,  32'h24, 0, 32'h0,  0, 1, 0, 32'h24, 32'h0,  0, 0, 32'h0);
    vecs[15] = mk(1, 0, 0, 0, 0, 1, 32'h10, 32'h0,  0, 32'h0,  0, 0, 0, 32'h0,  32'h0,  0, 1, 32'hAB);
    vecs[16] = mk(1, 0, 0, 0, 0, 0, 32'h10, 32'h0,  0, 32'h0,  0, 0, 0, 32'h0,  32'h0,  0, 0, 32'h0);
    vecs[17] = mk(1, 0, 0, 0, 0, 0, 32'h10, 32'h0,  0, 32'h0,  1, 0, 0, 32'h10, 32'h0,  0, 0, 32'h0);
    vecs[18] = mk(1, 1, 0, 0, 1, 0, 32'h28, 32'h18, 0, 32'h0,  0, 1, 0, 32'h18, 32'h0,  1, 0, 32'hDEADBEEF);
    vecs[19] = mk(1, 1, 0, 0, 1, 0, 32'h28, 32'h18, 0, 32'h0,  1, 0, 0, 32'h28, 32'h0,  0, 1, 32'h18181818);
    vecs[20] = mk(1, 1, 0, 0, 0, 0, 32'h2C, 32'h18, 0, 32'h0,  1, 0, 0, 32'h2C, 32'h0,  1, 0, 32'hAC);
    vecs[21] = mk(0, 1, 0, 0, 0, 0, 32'h0,  32'h18, 0, 32'h0,  0, 1, 0, 32'h18, 32'h0,  1, 0, 32'hAD);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 32'h0,  0, 0, 0, 32'h0,  32'h0,  0, 1, 32'h18181818);

    // Reset held with a pending request: nothing may be granted
    Reset = 1'b0;
    drv(1, 1, 0, 0, 0, 0, 32'h10, 32'h18, 0, 0);
    @(negedge CLK); #2;
    chk("reset gnt", {62'd0, gnt_c, gnt_e}, 64'd0);
    chk("reset mem_en", {63'd0, mem_en}, 64'd0);
    chk("reset rvalid", {62'd0, rvalid_c, rvalid_e}, 64'd0);
    @(negedge CLK);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge CLK);
      drv(vecs[i].rc, vecs[i].re, vecs[i].wc, vecs[i].we, vecs[i].lc, vecs[i].le,
          vecs[i].ac, vecs[i].ae, vecs[i].dc, vecs[i].de);
      #2;
      chk($sformatf("v%0d gnt", i), {62'd0, gnt_c, gnt_e}, {62'd0, vecs[i].gc, vecs[i].ge});
      chk($sformatf("v%0d en_we", i), {62'd0, mem_en, mem_we},
          {62'd0, vecs[i].gc | vecs[i].ge, vecs[i].mwe});
      chk($sformatf("v%0d addr", i), {32'd0, mem_addr}, {32'd0, vecs[i].ma});
      chk($sformatf("v%0d wdata", i), {32'd0, mem_wdata}, {32'd0, vecs[i].md});
      chk($sformatf("v%0d rvalid", i), {62'd0, rvalid_c, rvalid_e}, {62'd0, vecs[i].rvc, vecs[i].rve});
      if (vecs[i].rvc) chk($sformatf("v%0d rdata_c", i), {32'd0, rdata_c}, {32'd0, vecs[i].rd});
      if (vecs[i].rve) chk($sformatf("v%0d rdata_e", i), {32'd0, rdata_e}, {32'd0, vecs[i].rd});
    end

    // Reset asserted mid-cycle while C owns the bus with a read outstanding
    @(negedge CLK);
    drv(1, 1, 0, 0, 1, 0, 32'h10, 32'h18, 0, 0);
    #2;
    chk("lockc gnt", {62'd0, gnt_c, gnt_e}, 64'd2);
    @(negedge CLK); #2;
    chk("lockc hold gnt", {62'd0, gnt_c, gnt_e}, 64'd2);
    chk("lockc rvalid_c", {63'd0, rvalid_c}, 64'd1);
    #1 Reset = 1'b0;
    #1;
    chk("async rst outs", {60'd0, gnt_c, gnt_e, mem_en, rvalid_c}, 64'd0);
    @(negedge CLK);
    Reset = 1'b1;
    drv(1, 1, 0, 0, 0, 0, 32'h10, 32'h18, 0, 0);
    #2;
    chk("post rst tie", {62'd0, gnt_c, gnt_e}, 64'd2);
    @(negedge CLK); #2;
    chk("post rst alt", {62'd0, gnt_c, gnt_e}, 64'd1);
    chk("post rst rvalid_c", {63'd0, rvalid_c}, 64'd1);
    chk("post rst rdata_c", {32'd0, rdata_c}, {32'd0, 32'hDEADBEEF});

    // E takes a lock alone, then C keeps requesting against it
    @(negedge CLK);
    drv(0, 1, 0, 1, 0, 1, 32'h0, 32'h30, 0, 32'hE0);
    #2;
    chk("starve start", {62'd0, gnt_c, gnt_e}, 64'd1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      drv(1, 1, 0, 1, 0, 1, 32'h10, 32'h30, 0, 32'(k));
      #2;
      chk($sformatf("starve k%0d gnt_c", k), {63'd0, gnt_c}, {63'd0, starve_en && (k == 9)});
      chk($sformatf("starve k%0d gnt_e", k), {63'd0, gnt_e}, {63'd0, !(starve_en && (k == 9))});
    end
    @(negedge CLK);
    drv(0, 1, 0, 1, 0, 1, 32'h0, 32'h30, 0, 32'hEE);
    #2;
    chk("starve resume", {62'd0, gnt_c, gnt_e}, 64'd1);
    chk("starve rvalid_c", {63'd0, rvalid_c}, {63'd0, starve_en});

    @(negedge CLK);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
